// File: rtl/ram_ctrl_pkg.sv
// Shared widths, sweep value, FSM encoding and request payload for the RAM access controller.
package ram_ctrl_pkg;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [DW-1:0] INIT_VALUE = DW'(8'h00);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_cmd_t;

endpackage

// File: rtl/ram_access_controller_if.sv
// Requester ports, clear/busy and RAM control pins of the RAM access controller.
interface ram_access_controller_if;
  import ram_ctrl_pkg::*;

  logic          clr;
  logic          busy;

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;

  logic [AW-1:0] ram_readAddress;
  logic [AW-1:0] ram_writeAddress;
  logic [DW-1:0] ram_writeData;
  logic          ram_writeEnable;
  logic          ram_readEn;
  logic [DW-1:0] ram_ReadData;

  // Requester / RAM-instance side
  modport master (
    output clr,
    input  busy,
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_rvalid,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_rvalid,
    input  ram_readAddress, ram_writeAddress, ram_writeData, ram_writeEnable, ram_readEn,
    output ram_ReadData
  );

  // Controller side
  modport slave (
    input  clr,
    output busy,
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_rvalid,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_rvalid,
    output ram_readAddress, ram_writeAddress, ram_writeData, ram_writeEnable, ram_readEn,
    input  ram_ReadData
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority flips on every grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio;  // 0: m0 wins a tie, 1: m1 wins a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end

endmodule

// File: rtl/ram_access_controller.sv
// Owns the shared 64x8 RAM: clear sweep after reset/clr, then one round-robin
// arbitrated read or write per cycle for requesters m0 and m1.
module ram_access_controller
  import ram_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  ram_access_controller_if.slave  bus
);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_next;
  logic [1:0]    gnt;
  logic          run_en;
  req_cmd_t      cmd;

  // clr takes priority over any request in RUN
  assign run_en = (state == ST_RUN) && !bus.clr;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.m1_req, bus.m0_req}),
    .en    (run_en),
    .gnt   (gnt)
  );

  assign bus.m0_ack = gnt[0];
  assign bus.m1_ack = gnt[1];

  always_comb begin
    cmd = '0;
    if (gnt[0])      cmd = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
    else if (gnt[1]) cmd = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};
  end

  // Next state, sweep counter and RAM pin muxing
  always_comb begin
    state_next           = state;
    cnt_next             = cnt;
    bus.ram_writeEnable  = 1'b0;
    bus.ram_writeAddress = '0;
    bus.ram_writeData    = '0;
    bus.ram_readEn       = 1'b0;
    bus.ram_readAddress  = '0;
    case (state)
      ST_INIT: begin
        bus.ram_writeEnable  = 1'b1;
        bus.ram_writeAddress = cnt;
        bus.ram_writeData    = INIT_VALUE;
        if (bus.clr) begin
          cnt_next = '0;
        end else if (cnt == AW'(DEPTH - 1)) begin
          cnt_next   = '0;
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      ST_RUN: begin
        if (bus.clr) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end else if (|gnt) begin
          if (cmd.we) begin
            bus.ram_writeEnable  = 1'b1;
            bus.ram_writeAddress = cmd.addr;
            bus.ram_writeData    = cmd.wdata;
          end else begin
            bus.ram_readEn      = 1'b1;
            bus.ram_readAddress = cmd.addr;
          end
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      bus.busy <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bus.busy <= (state_next == ST_INIT);
    end
  end

  // Read data is captured on the grant edge; rvalid follows one cycle after ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m0_rdata  <= '0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
    end else begin
      bus.m0_rvalid <= gnt[0] && !cmd.we;
      bus.m1_rvalid <= gnt[1] && !cmd.we;
      if (gnt[0] && !cmd.we) bus.m0_rdata <= bus.ram_ReadData;
      if (gnt[1] && !cmd.we) bus.m1_rdata <= bus.ram_ReadData;
    end
  end

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: RAM model, directed vector table, corner sequences
// and a randomized phase checked against a shadow-memory reference model.
module tb_ram_access_controller;
  import ram_ctrl_pkg::*;

  typedef struct packed {
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          clr;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  k0;
    logic  k1;
    int    rd0;  // -1: no rvalid expected this cycle
    int    rd1;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_access_controller_if bus();

  ram_access_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // The RAM instance the controller drives
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_writeEnable) mem[bus.ram_writeAddress] <= bus.ram_writeData;
  assign bus.ram_ReadData = mem[bus.ram_readAddress];

  // Reference model state
  bit            m_busy;
  int            m_idx;
  int            m_prio;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_rv [2];
  logic [DW-1:0] m_rd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_idx  = 0;
    m_prio = 0;
    m_rv   = '{1'b0, 1'b0};
    m_rd   = '{DW'(0), DW'(0)};
  endtask

  task automatic drive(input stim_t s);
    bus.m0_req   = s.r0;
    bus.m0_we    = s.w0;
    bus.m0_addr  = s.a0;
    bus.m0_wdata = s.d0;
    bus.m1_req   = s.r1;
    bus.m1_we    = s.w1;
    bus.m1_addr  = s.a1;
    bus.m1_wdata = s.d1;
    bus.clr      = s.clr;
  endtask

  // One clock cycle: drive, check against the model, then advance the model over the edge
  task automatic cycle(input stim_t s, output int win);
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    @(negedge clk);
    drive(s);
    #1;
    win = -1;
    if (!m_busy && !s.clr) begin
      if (s.r0 && s.r1) win = m_prio;
      else if (s.r0)    win = 0;
      else if (s.r1)    win = 1;
    end
    we   = (win == 1) ? s.w1 : s.w0;
    addr = (win == 1) ? s.a1 : s.a0;
    data = (win == 1) ? s.d1 : s.d0;
    chk("ack0", 32'(bus.m0_ack), 32'(win == 0));
    chk("ack1", 32'(bus.m1_ack), 32'(win == 1));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("rvalid0", 32'(bus.m0_rvalid), 32'(m_rv[0]));
    chk("rvalid1", 32'(bus.m1_rvalid), 32'(m_rv[1]));
    chk("rdata0", 32'(bus.m0_rdata), 32'(m_rd[0]));
    chk("rdata1", 32'(bus.m1_rdata), 32'(m_rd[1]));
    if (m_busy) begin
      chk("sweep_we", 32'(bus.ram_writeEnable), 32'(1));
      chk("sweep_addr", 32'(bus.ram_writeAddress), 32'(m_idx));
      chk("sweep_data", 32'(bus.ram_writeData), 32'(INIT_VALUE));
    end else if (win < 0) begin
      chk("idle_we", 32'(bus.ram_writeEnable), 32'(0));
      chk("idle_re", 32'(bus.ram_readEn), 32'(0));
    end else if (we) begin
      chk("wr_we", 32'(bus.ram_writeEnable), 32'(1));
      chk("wr_addr", 32'(bus.ram_writeAddress), 32'(addr));
      chk("wr_data", 32'(bus.ram_writeData), 32'(data));
      chk("wr_re", 32'(bus.ram_readEn), 32'(0));
    end else begin
      chk("rd_re", 32'(bus.ram_readEn), 32'(1));
      chk("rd_addr", 32'(bus.ram_readAddress), 32'(addr));
      chk("rd_we", 32'(bus.ram_writeEnable), 32'(0));
    end
    m_rv = '{1'b0, 1'b0};
    if (m_busy) begin
      m_mem[m_idx] = INIT_VALUE;
      if (s.clr) m_idx = 0;
      else if (m_idx == int'(DEPTH) - 1) begin m_idx = 0; m_busy = 1'b0; end
      else m_idx++;
    end else if (s.clr) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (win >= 0) begin
      if (we) m_mem[addr] = data;
      else begin
        m_rd[win] = m_mem[addr];
        m_rv[win] = 1'b1;
      end
      m_prio = 1 - win;
    end
  endtask

  function automatic vec_t v(input logic r0, w0, input int a0, d0,
                             input logic r1, w1, input int a1, d1,
                             input logic clr, k0, k1, input int rd0, rd1);
    vec_t t;
    t.s   = '{r0: r0, w0: w0, a0: AW'(a0), d0: DW'(d0),
              r1: r1, w1: w1, a1: AW'(a1), d1: DW'(d1), clr: clr};
    t.k0  = k0;
    t.k1  = k1;
    t.rd0 = rd0;
    t.rd1 = rd1;
    return t;
  endfunction

  initial begin
    vec_t  tbl [17];
    stim_t s;
    stim_t ps [2];
    bit    pend [2];
    int    win;
    int    n;
    int    nack;

    rst_n = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'(1));
    chk("rst_rvalid0", 32'(bus.m0_rvalid), 32'(0));
    chk("rst_rdata1", 32'(bus.m1_rdata), 32'(0));
    chk("rst_we", 32'(bus.ram_writeEnable), 32'(1));
    chk("rst_waddr", 32'(bus.ram_writeAddress), 32'(0));
    #1 rst_n = 1'b1;
    model_reset();

    // Sweep after reset release lasts exactly DEPTH cycles
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle('0, win);
      if (bus.busy) n++;
      else break;
    end
    chk("t1_sweep_len", 32'(n), 32'(DEPTH));

    tbl[0]  = v(1, 0, 1, 0,     1, 0, 2, 0,     0, 1, 0, -1, -1);
    tbl[1]  = v(1, 0, 1, 0,     1, 0, 2, 0,     0, 0, 1, 0, -1);
    tbl[2]  = v(1, 0, 1, 0,     1, 0, 2, 0,     0, 1, 0, -1, 0);
    tbl[3]  = v(1, 0, 1, 0,     1, 0, 2, 0,     0, 0, 1, 0, -1);
    tbl[4]  = v(1, 0, 63, 0,    0, 0, 0, 0,     0, 1, 0, -1, 0);
    tbl[5]  = v(1, 1, 5, 'h3A,  0, 0, 0, 0,     0, 1, 0, 0, -1);
    tbl[6]  = v(1, 0, 5, 0,     0, 0, 0, 0,     0, 1, 0, -1, -1);
    tbl[7]  = v(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 'h3A, -1);
    tbl[8]  = v(0, 0, 0, 0,     1, 1, 9, 'hC7,  0, 0, 1, -1, -1);
    tbl[9]  = v(1, 0, 9, 0,     0, 0, 0, 0,     0, 1, 0, -1, -1);
    tbl[10] = v(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0, 'hC7, -1);
    tbl[11] = v(0, 0, 0, 0,     1, 0, 5, 0,     0, 0, 1, -1, -1);
    tbl[12] = v(1, 1, 7, 'h11,  1, 1, 8, 'h22,  0, 1, 0, -1, 'h3A);
    tbl[13] = v(0, 0, 0, 0,     1, 1, 8, 'h22,  0, 0, 1, -1, -1);
    tbl[14] = v(1, 0, 7, 0,     1, 0, 8, 0,     0, 1, 0, -1, -1);
    tbl[15] = v(0, 0, 0, 0,     1, 0, 8, 0,     0, 0, 1, 'h11, -1);
    tbl[16] = v(1, 0, 5, 0,     1, 0, 9, 0,     1, 0, 0, -1, 'h22);

    foreach (tbl[i]) begin
      cycle(tbl[i].s, win);
      chk($sformatf("tbl%0d_ack0", i), 32'(bus.m0_ack), 32'(tbl[i].k0));
      chk($sformatf("tbl%0d_ack1", i), 32'(bus.m1_ack), 32'(tbl[i].k1));
      chk($sformatf("tbl%0d_rv0", i), 32'(bus.m0_rvalid), 32'(tbl[i].rd0 >= 0));
      chk($sformatf("tbl%0d_rv1", i), 32'(bus.m1_rvalid), 32'(tbl[i].rd1 >= 0));
      if (tbl[i].rd0 >= 0) chk($sformatf("tbl%0d_rd0", i), 32'(bus.m0_rdata), 32'(tbl[i].rd0));
      if (tbl[i].rd1 >= 0) chk($sformatf("tbl%0d_rd1", i), 32'(bus.m1_rdata), 32'(tbl[i].rd1));
    end

    // clr with both requesting: requests wait out the sweep, then resume in round-robin order
    n    = 0;
    nack = 0;
    s    = tbl[16].s;
    s.clr = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cycle(s, win);
      if (!bus.busy) break;
      n++;
      if (bus.m0_ack || bus.m1_ack) nack++;
    end
    chk("t4_sweep_len", 32'(n), 32'(DEPTH));
    chk("t4_acks_in_sweep", 32'(nack), 32'(0));
    chk("t4_first_ack0", 32'(bus.m0_ack), 32'(1));
    s.r0 = 1'b0;
    cycle(s, win);
    chk("t4_second_ack1", 32'(bus.m1_ack), 32'(1));
    for (int a = 0; a < int'(DEPTH); a++) begin
      s = '0;
      s.r0 = 1'b1;
      s.a0 = AW'(a);
      cycle(s, win);
      @(posedge clk);
      #1;
      chk($sformatf("t4_word%0d", a), 32'(bus.m0_rdata), 32'(INIT_VALUE));
    end

    // Reset in the middle of a sweep, at cnt = 20
    s = '0;
    s.clr = 1'b1;
    cycle(s, win);
    repeat (20) cycle('0, win);
    @(negedge clk);
    #1;
    chk("t5_cnt20", 32'(bus.ram_writeAddress), 32'(20));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_waddr", 32'(bus.ram_writeAddress), 32'(0));
    chk("t5_rst_busy", 32'(bus.busy), 32'(1));
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      cycle('0, win);
      if (bus.busy) n++;
      else break;
    end
    chk("t5_sweep_len", 32'(n), 32'(DEPTH));

    // Reset between a read ack and its rvalid drops the rvalid
    @(negedge clk);
    s = '0;
    s.r0 = 1'b1;
    s.a0 = AW'(9);
    drive(s);
    #1;
    chk("rr_ack", 32'(bus.m0_ack), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rr_ack_in_rst", 32'(bus.m0_ack), 32'(0));
    chk("rr_re_in_rst", 32'(bus.ram_readEn), 32'(0));
    @(posedge clk);
    #1;
    chk("rr_rvalid", 32'(bus.m0_rvalid), 32'(0));
    chk("rr_rdata", 32'(bus.m0_rdata), 32'(0));
    drive('0);
    model_reset();
    #1 rst_n = 1'b1;

    // Randomized traffic: held requests, occasional abandon, rare clr
    pend = '{1'b0, 1'b0};
    ps   = '{'0, '0};
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && $urandom_range(0, 49) == 0) begin
          pend[p] = 1'b0;
        end else if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]     = 1'b1;
          ps[p].r0    = 1'b1;
          ps[p].w0    = 1'($urandom_range(0, 1));
          ps[p].a0    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
          ps[p].d0    = DW'($urandom);
        end
      end
      s     = '0;
      s.r0  = pend[0];
      s.w0  = ps[0].w0;
      s.a0  = ps[0].a0;
      s.d0  = ps[0].d0;
      s.r1  = pend[1];
      s.w1  = ps[1].w0;
      s.a1  = ps[1].a0;
      s.d1  = ps[1].d0;
      s.clr = ($urandom_range(0, 299) == 0);
      cycle(s, win);
      if (win >= 0) pend[win] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
